// File: rtl/btn_conditioner.sv
// btn_conditioner: per-button synchroniser, debounce FSM, clean level and one-cycle press pulse.
// Define AUTO_REPEAT_EN to add auto-repeat pulses while a button is held.
module btn_conditioner #(
  parameter int NUM_BTN       = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 15000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q;
  always_ff @(posedge clk)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_ch
    state_t st;
    logic [CW-1:0] cnt;
    logic s, db_done, lvl, pls;
    assign s = sync_q[SYNC_STAGES-1][b];
    assign db_done = cnt == CW'(DB_CYCLES - 1);
    assign btn_level[b] = lvl;
    assign btn_pulse[b] = pls;
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rcnt;
    logic rep;
    assign rep = rcnt == RW'(REPEAT_DELAY - 1);
    // After each repeat, reload so the next match lands REPEAT_PERIOD cycles later
    always_ff @(posedge clk)
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        rcnt <= '0;
        lvl <= 1'b0;
        pls <= 1'b0;
      end else begin
        pls <= 1'b0;
        case (st)
          IDLE: if (s) begin st <= DB_PRESS; cnt <= '0; end
          DB_PRESS:
            if (!s) st <= IDLE;
            else if (db_done) begin st <= HELD; lvl <= 1'b1; pls <= 1'b1; rcnt <= '0; end
            else cnt <= cnt + 1'b1;
          HELD:
            if (!s) begin st <= DB_RELEASE; cnt <= '0; rcnt <= '0; end
            else if (rep) begin pls <= 1'b1; rcnt <= RW'(REPEAT_DELAY - REPEAT_PERIOD); end
            else rcnt <= rcnt + 1'b1;
          DB_RELEASE:
            if (s) begin st <= HELD; rcnt <= '0; end
            else if (db_done) begin st <= IDLE; lvl <= 1'b0; end
            else cnt <= cnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
`else
    always_ff @(posedge clk)
      if (reset) begin
        st <= IDLE;
        cnt <= '0;
        lvl <= 1'b0;
        pls <= 1'b0;
      end else begin
        pls <= 1'b0;
        case (st)
          IDLE: if (s) begin st <= DB_PRESS; cnt <= '0; end
          DB_PRESS:
            if (!s) st <= IDLE;
            else if (db_done) begin st <= HELD; lvl <= 1'b1; pls <= 1'b1; end
            else cnt <= cnt + 1'b1;
          HELD: if (!s) begin st <= DB_RELEASE; cnt <= '0; end
          DB_RELEASE:
            if (s) st <= HELD;
            else if (db_done) begin st <= IDLE; lvl <= 1'b0; end
            else cnt <= cnt + 1'b1;
          default: st <= IDLE;
        endcase
      end
`endif
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce latency, glitch rejection, reset and optional auto-repeat.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] btn_raw, btn_level, btn_pulse;
  int n_checks = 0, n_fail = 0;
  int npulse, w;
`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  btn_conditioner #(.NUM_BTN(5), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    btn_raw = '0;
    repeat (3) tick();
    check("rst_level", btn_level, 0);
    check("rst_pulse", btn_pulse, 0);
    reset = 1'b0;
    // clean press on channel 0, held; repeats expected only with AUTO_REPEAT_EN
    btn_raw = 5'b00001;
    for (int k = 1; k <= 47; k++) begin
      tick();
      check("t1_level", btn_level, k >= 7 ? 1 : 0);
      check("t1_pulse", btn_pulse, (k == 7 || (AR && k >= 17 && (k - 17) % 5 == 0)) ? 1 : 0);
    end
    btn_raw = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t1_rel_level", btn_level, k < 7 ? 1 : 0);
      check("t1_rel_pulse", btn_pulse, 0);
    end
    // press glitch on channel 4
    btn_raw = 5'b10000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t2_level", btn_level, 0);
      check("t2_pulse", btn_pulse, 0);
      if (k == 3) btn_raw = '0;
    end
    // release bounce on channel 1
    btn_raw = 5'b00010;
    repeat (8) tick();
    check("t3_held", btn_level, 5'b00010);
    btn_raw = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t3_level", btn_level, k < 10 ? 5'b00010 : 0);
      check("t3_pulse", btn_pulse, 0);
      if (k == 2) btn_raw = 5'b00010;
      if (k == 3) btn_raw = '0;
    end
    // simultaneous press, then reset while held
    btn_raw = 5'b01100;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t4_level", btn_level, k >= 7 ? 5'b01100 : 0);
      check("t4_pulse", btn_pulse, k == 7 ? 5'b01100 : 0);
    end
    reset = 1'b1;
    tick();
    check("t4_rst_level", btn_level, 0);
    check("t4_rst_pulse", btn_pulse, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("t4b_level", btn_level, k >= 7 ? 5'b01100 : 0);
      check("t4b_pulse", btn_pulse, k == 7 ? 5'b01100 : 0);
    end
    btn_raw = '0;
    repeat (10) tick();
    check("t4_idle", btn_level, 0);
    // five back-to-back presses on channel 0
    npulse = 0;
    w = 0;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 22; k++) begin
        btn_raw = k < 10 ? 5'b00001 : 5'b00000;
        tick();
        if (btn_pulse[0]) begin
          w++;
          if (w == 1) npulse++;
        end else if (w != 0) begin
          check("t6_width", w, 1);
          w = 0;
        end
      end
    end
    check("t6_count", npulse, 5);
    check("t6_level", btn_level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
